plane_xor_cipher: RTL and testbench
===================================

// Module: plane_xor_cipher
// PURPOSE
//  Downstream stage of the RGB plane separator. Reads the three separated colour
//  planes (B, G, R) from the shared 16-bit async SRAM. XORs every word with a key
//  stream and writes the cipher words to a contiguous cipher region.
//  Owns the SRAM bus from start until done; the separator must be idle (led=1) first.
// PARAMETERS
//  PLANE0_BASE  18'h0C500  B-plane source base (word address)
//  PLANE1_BASE  18'h0E500  G-plane source base
//  PLANE2_BASE  18'h10500  R-plane source base
//  PLANE_WORDS  8192       words per plane (128x128 image, 2 pixels/word)
//  CIPHER_BASE  18'h12500  cipher output base; plane p word w -> CIPHER_BASE+p*PLANE_WORDS+w
//  KEY_DEFAULT  16'hACE1   substituted when key input is 16'h0000
// PORTS
//  clk          in     1   system clock, all state on rising edge
//  reset        in     1   asynchronous, ACTIVE-LOW reset (0 = reset)
//  start        in     1   1-cycle pulse, sampled in IDLE/DONE only
//  key          in    16   seed/key, captured on accepted start
//  databus1     inout 16   SRAM data; driven only in WR/WRH, else 16'hzzzz
//  addressbus2  out   18   SRAM word address
//  ce           out    1   chip enable, constant 0
//  oe           out    1   output enable, active low
//  we           out    1   write enable, active low
//  lsb, msb     out    1   byte enables, constant 0
//  busy         out    1   1 from accepted start until DONE entered
//  led          out    1   done flag, 1 in DONE until next start
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=IDLE; oe=1, we=1, busy=0, led=0, addressbus2=0, databus1 released.
//    - Counters cleared.
//    - Mid-run reset aborts immediately; the partial cipher region is left as is.
//  - FSM, 5 clocks per word:
//    - IDLE: on start -> RD. Capture key (0 -> KEY_DEFAULT) into ks. plane=0, word=0, busy=1.
//    - RD: addr=PLANEx_BASE+word, oe=0 -> CAP.
//    - CAP: sample databus1; data=databus1^ks; oe=1 -> WR.
//    - WR: addr=CIPHER_BASE+plane*PLANE_WORDS+word; drive data; we=0 -> WRH.
//    - WRH: we=1; keep driving and hold addr (write commits on we rise) -> NEXT.
//    - NEXT: release bus; advance ks (see CONFIGURATION); word+=1.
//      - If word==PLANE_WORDS-1: word=0, plane+=1.
//      - If plane==2 and last word: -> DONE, else -> RD.
//    - DONE: busy=0, led=1, oe=we=1. Start -> RD (re-run, led cleared same edge).
//  - Bus is never driven while oe=0: one idle half-word turnaround via CAP/NEXT.
//  - start while busy: ignored. start and reset together: reset wins.
//  - Address arithmetic: 18-bit unsigned, wraps mod 2^18 (no overflow with defaults:
//    last write 18'h184FF).
//  - word counter 13 bits, plane counter 2 bits (values 0..2 only).
//  - Total run: 3*PLANE_WORDS*5 = 122880 clocks from start edge to DONE entry.
//  - Key stream word k applies to the k-th word overall (plane order B,G,R, continuous
//    across planes, not reseeded).
// CONFIGURATION
//  KEYSTREAM_EN defined:
//    - ks is a 16-bit Galois LFSR, right shift, mask 16'hB400, advanced once per word in NEXT.
//    - ks = ks[0] ? (ks>>1)^16'hB400 : ks>>1.
//  KEYSTREAM_EN undefined: ks constant = captured key for the whole run (LFSR logic absent).
//  Encryption is an involution: running the block on cipher data with the same key
//  restores the plaintext.
// TESTING
//  1 Reset: hold reset=0 at mid-run (word 100) -> oe=1, we=1, busy=0, led=0, bus hi-Z
//    within the reset cycle. No further writes.
//  2 Const key (no macro): key=16'h00FF, B word0=16'h1234 -> SRAM[18'h12500]=16'h12CB.
//    led=1 after exactly 122880 clocks.
//  3 LFSR (macro): key=16'h0001, B w0=16'h1234, w1=16'h0000 -> [12500]=16'h1235, [12501]=16'hB400.
//  4 Plane boundary: G w0=16'hFFFF, key=16'h0F0F (no macro) -> SRAM[18'h14500]=16'hF0F0.
//    R last word written at 18'h184FF.
//  5 Zero key: key=16'h0000, word=16'h0000 -> first cipher word=16'hACE1.
//    start pulses while busy are ignored (run length unchanged).
//  6 Round trip: copy the cipher region to the plane bases, rerun with the same key
//    -> all 24576 words equal the original. Bus monitor flags no oe=0 while the block drives.

Source files
------------

// File: rtl/plane_xor_cipher.sv
// plane_xor_cipher: reads the B/G/R planes from async SRAM, XORs each word
// with a key stream and writes a contiguous cipher region.
// Ports: clk, reset (async, active-low), start/key in; SRAM bus databus1
// (inout), addressbus2, ce/oe/we/lsb/msb; status busy and led (done).
// Optional macro KEYSTREAM_EN: ks becomes a 16-bit Galois LFSR (mask B400)
// advanced once per word; without it ks stays at the captured key.
module plane_xor_cipher #(
    parameter logic [17:0] PLANE0_BASE = 18'h0C500,
    parameter logic [17:0] PLANE1_BASE = 18'h0E500,
    parameter logic [17:0] PLANE2_BASE = 18'h10500,
    parameter int          PLANE_WORDS = 8192,
    parameter logic [17:0] CIPHER_BASE = 18'h12500,
    parameter logic [15:0] KEY_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] key,
    inout  wire  [15:0] databus1,
    output logic [17:0] addressbus2,
    output logic        ce,
    output logic        oe,
    output logic        we,
    output logic        lsb,
    output logic        msb,
    output logic        busy,
    output logic        led
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_WR, S_WRH, S_NEXT, S_DONE
    } state_t;

    state_t      state, state_d;
    logic [12:0] word, word_d;
    logic [1:0]  plane, plane_d;
    logic [15:0] ks, ks_d;
    logic [15:0] data_q, data_d;
    logic [17:0] addr_q, addr_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        drv_q, drv_d;
    logic        busy_q, busy_d;
    logic        led_q, led_d;
    logic        last_word;

    function automatic logic [17:0] src_base(input logic [1:0] p);
        logic [17:0] b;
        unique case (1'b1)
            (p == 2'd0): b = PLANE0_BASE;
            (p == 2'd1): b = PLANE1_BASE;
            default:     b = PLANE2_BASE;
        endcase
        return b;
    endfunction

`ifdef KEYSTREAM_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
`endif

    assign last_word = (word == 13'(PLANE_WORDS - 1));

    // Outputs are registered copies of the values chosen for the next
    // state, so each state's bus levels hold for its whole clock.
    always_comb begin
        state_d = state;
        word_d  = word;
        plane_d = plane;
        ks_d    = ks;
        data_d  = data_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        we_d    = we_q;
        drv_d   = drv_q;
        busy_d  = busy_q;
        led_d   = led_q;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RD;
                    ks_d    = (key == 16'h0000) ? KEY_DEFAULT : key;
                    word_d  = '0;
                    plane_d = '0;
                    busy_d  = 1'b1;
                    led_d   = 1'b0;
                    addr_d  = PLANE0_BASE;
                    oe_d    = 1'b0;
                end
            end
            S_RD: begin
                // Capture on the edge that ends the oe=0 cycle.
                state_d = S_CAP;
                data_d  = databus1 ^ ks;
                oe_d    = 1'b1;
            end
            S_CAP: begin
                state_d = S_WR;
                addr_d  = CIPHER_BASE
                        + 18'(plane) * 18'(PLANE_WORDS)
                        + 18'(word);
                we_d    = 1'b0;
                drv_d   = 1'b1;
            end
            S_WR: begin
                // we rises here; data and address stay put.
                state_d = S_WRH;
                we_d    = 1'b1;
            end
            S_WRH: begin
                state_d = S_NEXT;
                drv_d   = 1'b0;
            end
            S_NEXT: begin
`ifdef KEYSTREAM_EN
                ks_d = lfsr_step(ks);
`endif
                if (last_word && plane == 2'd2) begin
                    state_d = S_DONE;
                    word_d  = '0;
                    busy_d  = 1'b0;
                    led_d   = 1'b1;
                end else begin
                    word_d  = last_word ? 13'd0 : word + 13'd1;
                    plane_d = last_word ? plane + 2'd1 : plane;
                    state_d = S_RD;
                    addr_d  = src_base(plane_d) + 18'(word_d);
                    oe_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            word   <= '0;
            plane  <= '0;
            ks     <= '0;
            data_q <= '0;
            addr_q <= '0;
            oe_q   <= 1'b1;
            we_q   <= 1'b1;
            drv_q  <= 1'b0;
            busy_q <= 1'b0;
            led_q  <= 1'b0;
        end else begin
            state  <= state_d;
            word   <= word_d;
            plane  <= plane_d;
            ks     <= ks_d;
            data_q <= data_d;
            addr_q <= addr_d;
            oe_q   <= oe_d;
            we_q   <= we_d;
            drv_q  <= drv_d;
            busy_q <= busy_d;
            led_q  <= led_d;
        end
    end

    assign databus1    = drv_q ? data_q : 16'hzzzz;
    assign addressbus2 = addr_q;
    assign oe          = oe_q;
    assign we          = we_q;
    assign busy        = busy_q;
    assign led         = led_q;
    assign ce          = 1'b0;
    assign lsb         = 1'b0;
    assign msb         = 1'b0;

endmodule

// File: tb/tb_plane_xor_cipher.sv
// tb_plane_xor_cipher: SRAM model plus write scoreboard for plane_xor_cipher.
// Uses a reduced plane size so full runs stay short.
module tb_plane_xor_cipher;

    localparam int          PW  = 32;
    localparam int          RUN = 3 * PW * 5;
    localparam logic [17:0] B0  = 18'h0C500;
    localparam logic [17:0] B1  = 18'h0E500;
    localparam logic [17:0] B2  = 18'h10500;
    localparam logic [17:0] CB  = 18'h12500;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] key = '0;
    wire  [15:0] databus1;
    logic [17:0] addressbus2;
    logic        ce, oe, we, lsb, msb, busy, led;

    logic [15:0] mem [0:(1<<18)-1];
    logic [15:0] plain [3*PW];
    logic        tb_pat = 1'b0;
    wr_t         sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          nwr = 0;
    int          viol = 0;
    logic [17:0] last_wr = '0;
    logic [17:0] base [3];

    always #5 clk = ~clk;

    assign databus1 = tb_pat ? 16'h5A5A
                    : ((!oe && we) ? mem[addressbus2] : 16'hzzzz);

    plane_xor_cipher #(.PLANE_WORDS(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .databus1(databus1), .addressbus2(addressbus2),
        .ce(ce), .oe(oe), .we(we), .lsb(lsb), .msb(msb),
        .busy(busy), .led(led)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ks_adv(input logic [15:0] s);
`ifdef KEYSTREAM_EN
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
`else
        return s;
`endif
    endfunction

    task automatic sb_load(input logic [15:0] k);
        logic [15:0] s;
        wr_t e;
        s = (k == 16'h0000) ? 16'hACE1 : k;
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < PW; w++) begin
                e.addr = CB + 18'(p * PW + w);
                e.data = mem[base[p] + 18'(w)] ^ s;
                sb.push_back(e);
                s = ks_adv(s);
            end
    endtask

    task automatic do_run(input logic [15:0] k, input bit noise);
        int cyc;
        sb_load(k);
        @(negedge clk);
        key = k;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_on", busy, 1);
        cyc = 0;
        while (cyc < RUN + 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (led) break;
            start = noise && (cyc % 37 == 5);
        end
        start = 1'b0;
        chk("run_len", cyc, RUN);
        chk("busy_off", busy, 0);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        int n0, n1, g;
        base[0] = B0;
        base[1] = B1;
        base[2] = B2;
        for (int i = 0; i < 3 * PW; i++)
            plain[i] = 16'($urandom);
        plain[0]  = 16'h1234;
        plain[PW] = 16'hFFFF;
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < PW; w++)
                mem[base[p] + 18'(w)] = plain[p * PW + w];

        fork
            forever @(posedge we) begin
                if (reset) begin
                    mem[addressbus2] = databus1;
                    last_wr = addressbus2;
                    nwr++;
                    if (sb.size() == 0) begin
                        chk("sb_extra", {14'd0, addressbus2}, 0);
                    end else begin
                        wr_t e;
                        e = sb.pop_front();
                        chk("wr_addr", {14'd0, addressbus2}, {14'd0, e.addr});
                        chk("wr_data", {16'd0, databus1}, {16'd0, e.data});
                    end
                end
            end
            begin
                logic prev_we_low;
                prev_we_low = 1'b0;
                forever @(negedge clk) begin
                    if (reset && !oe && (!we || prev_we_low)) viol++;
                    prev_we_low = !we;
                end
            end
        join_none

        // reset state
        tb_pat = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", oe, 1);
        chk("rst_we", we, 1);
        chk("rst_busy", busy, 0);
        chk("rst_led", led, 0);
        chk("rst_addr", {14'd0, addressbus2}, 0);
        chk("rst_const", {ce, lsb, msb}, 0);
        chk("rst_bus", {16'd0, databus1}, 32'h5A5A);
        tb_pat = 1'b0;
        @(negedge clk) reset = 1'b1;

        // constant-key run, first word and last address
        do_run(16'h00FF, 1'b0);
        chk("led_done", led, 1);
        chk("first_ct", {16'd0, mem[CB]}, 32'h12CB);
        chk("last_addr", {14'd0, last_wr}, {14'd0, CB + 18'(3 * PW - 1)});

        // round trip: cipher back into the plane bases
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < PW; w++)
                mem[base[p] + 18'(w)] = mem[CB + 18'(p * PW + w)];
        do_run(16'h00FF, 1'b0);
        for (int i = 0; i < 3 * PW; i++)
            chk("round_trip", {16'd0, mem[CB + 18'(i)]}, {16'd0, plain[i]});

        // plane boundary
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < PW; w++)
                mem[base[p] + 18'(w)] = plain[p * PW + w];
        do_run(16'h0F0F, 1'b0);
`ifndef KEYSTREAM_EN
        chk("g_w0", {16'd0, mem[CB + 18'(PW)]}, 32'hF0F0);
`endif
        chk("r_last", {14'd0, last_wr}, {14'd0, CB + 18'(3 * PW - 1)});

        // zero key with start pulses while busy
        mem[B0] = 16'h0000;
        do_run(16'h0000, 1'b1);
        chk("zero_key", {16'd0, mem[CB]}, 32'hACE1);

        // mid-run reset
        sb_load(16'h1234);
        @(negedge clk);
        key = 16'h1234;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n0 = nwr;
        g = 0;
        while (nwr < n0 + 40 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        chk("mid_reach", nwr >= n0 + 40, 1);
        @(negedge clk);
        reset = 1'b0;
        tb_pat = 1'b1;
        #1;
        chk("mid_oe", oe, 1);
        chk("mid_we", we, 1);
        chk("mid_busy", busy, 0);
        chk("mid_led", led, 0);
        chk("mid_bus", {16'd0, databus1}, 32'h5A5A);
        repeat (4) @(posedge clk);
        @(negedge clk);
        tb_pat = 1'b0;
        reset = 1'b1;
        n1 = nwr;
        repeat (50) @(posedge clk);
        #1;
        chk("no_writes", nwr, n1);
        chk("idle_busy", busy, 0);
        sb.delete();

        chk("bus_conflict", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
